// File: rtl/ecc_host_if_if.sv
// Host-side request/response bundle for the ECC host adapter.
// master: host (drives req_*, rsp_ready); slave: adapter (drives req_ready, rsp_*).
interface ecc_host_if_if #(
   parameter int SIZE = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [SIZE-1:0] req_a;
   logic [SIZE-1:0] req_prime;
   logic [SIZE-1:0] req_px;
   logic [SIZE-1:0] req_py;
   logic [SIZE-1:0] req_k;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [SIZE-1:0] rsp_x;
   logic [SIZE-1:0] rsp_y;
   logic            rsp_err;

   modport master (
      output req_valid, req_a, req_prime, req_px, req_py, req_k,
      output rsp_ready,
      input  req_ready, rsp_valid, rsp_x, rsp_y, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_prime, req_px, req_py, req_k,
      input  rsp_ready,
      output req_ready, rsp_valid, rsp_x, rsp_y, rsp_err
   );
endinterface

// File: rtl/ecc_host_if.sv
// Parallel-to-nibble-serial adapter between a host and an ECC kP core.
// Ports: i_clk, i_rst (async high); host (slave modport: req/rsp handshakes);
// o_start, o_a..o_k (serial operands out); kPx, kPy, done (serial result in).
module ecc_host_if #(
   parameter int SIZE    = 32,
   parameter int NIB     = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic           i_clk,
   input  logic           i_rst,
   ecc_host_if_if.slave   host,
   output logic           o_start,
   output logic [NIB-1:0] o_a,
   output logic [NIB-1:0] o_prime,
   output logic [NIB-1:0] o_px,
   output logic [NIB-1:0] o_py,
   output logic [NIB-1:0] o_k,
   input  logic [NIB-1:0] kPx,
   input  logic [NIB-1:0] kPy,
   input  logic           done
);
   localparam int N  = SIZE / NIB;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_WAIT, S_RECV, S_HOLD
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic [WW-1:0]   r_wcnt;
   logic [SIZE-1:0] r_a, r_p, r_x, r_y, r_k;
   logic [SIZE-1:0] r_rx, r_ry;
   logic            r_err;
   logic            w_last;
   logic            w_tmo;

   assign w_last = (r_cnt == CW'(N - 1));
   assign w_tmo  = (r_wcnt == WW'(TIMEOUT - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // done is only honoured in WAIT; it wins over a same-cycle timeout
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (host.req_valid) w_next = S_SEND;
         S_SEND:  if (w_last) w_next = S_WAIT;
         S_WAIT: begin
            if (done)       w_next = S_RECV;
            else if (w_tmo) w_next = S_HOLD;
         end
         S_RECV:  if (w_last) w_next = S_HOLD;
         S_HOLD:  if (host.rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_wcnt <= '0;
         r_a    <= '0;
         r_p    <= '0;
         r_x    <= '0;
         r_y    <= '0;
         r_k    <= '0;
         r_rx   <= '0;
         r_ry   <= '0;
         r_err  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (host.req_valid) begin
                  r_a   <= host.req_a;
                  r_p   <= host.req_prime;
                  r_x   <= host.req_px;
                  r_y   <= host.req_py;
                  r_k   <= host.req_k;
                  r_cnt <= '0;
                  r_rx  <= '0;
                  r_ry  <= '0;
                  r_err <= 1'b0;
               end
            end
            S_SEND: begin
               r_a   <= r_a >> NIB;
               r_p   <= r_p >> NIB;
               r_x   <= r_x >> NIB;
               r_y   <= r_y >> NIB;
               r_k   <= r_k >> NIB;
               r_cnt <= w_last ? '0 : r_cnt + 1'b1;
               if (w_last) r_wcnt <= '0;
            end
            S_WAIT: begin
               r_wcnt <= r_wcnt + 1'b1;
               if (done)       r_cnt <= '0;
               else if (w_tmo) r_err <= 1'b1;
            end
            S_RECV: begin
               // shift in from the top: nibble 0 ends at the LSBs
               r_rx  <= {kPx, r_rx[SIZE-1:NIB]};
               r_ry  <= {kPy, r_ry[SIZE-1:NIB]};
               r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // results are gated by HOLD so partial captures never leak out
   always_comb begin
      host.req_ready = (r_state == S_IDLE);
      host.rsp_valid = (r_state == S_HOLD);
      host.rsp_err   = (r_state == S_HOLD) && r_err;
      host.rsp_x     = '0;
      host.rsp_y     = '0;
      o_start        = (r_state == S_SEND) && (r_cnt == '0);
      o_a            = '0;
      o_prime        = '0;
      o_px           = '0;
      o_py           = '0;
      o_k            = '0;
      if (r_state == S_HOLD && !r_err) begin
         host.rsp_x = r_rx;
         host.rsp_y = r_ry;
      end
      if (r_state == S_SEND) begin
         o_a     = r_a[NIB-1:0];
         o_prime = r_p[NIB-1:0];
         o_px    = r_x[NIB-1:0];
         o_py    = r_y[NIB-1:0];
         o_k     = r_k[NIB-1:0];
      end
   end
endmodule

// File: tb/tb_ecc_host_if.sv
// Directed self-checking bench for ecc_host_if (SIZE=32, NIB=4, TIMEOUT=16).
// Drives the host interface and a hand-scripted core model.
module tb_ecc_host_if;
   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       o_start;
   logic [3:0] o_a, o_prime, o_px, o_py, o_k;
   logic [3:0] kPx = 4'h0;
   logic [3:0] kPy = 4'h0;
   logic       done = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   ecc_host_if_if #(.SIZE(32)) hif ();

   ecc_host_if #(.SIZE(32), .NIB(4), .TIMEOUT(16)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .host    (hif),
      .o_start (o_start),
      .o_a     (o_a),
      .o_prime (o_prime),
      .o_px    (o_px),
      .o_py    (o_py),
      .o_k     (o_k),
      .kPx     (kPx),
      .kPy     (kPy),
      .done    (done)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // issue one request and check all 8 SEND nibbles; optional spurious done
   task automatic send_req(input logic [31:0] a, input int spur);
      logic [31:0] p, x, y, k;
      p = ~a;
      x = a ^ 32'h0F0F_0F0F;
      y = {a[15:0], a[31:16]};
      k = a + 32'h1111_1111;
      hif.req_a     = a;
      hif.req_prime = p;
      hif.req_px    = x;
      hif.req_py    = y;
      hif.req_k     = k;
      hif.req_valid = 1'b1;
      check("idle_ready", 64'(hif.req_ready), 64'd1);
      step();
      hif.req_valid = 1'b0;
      for (int n = 0; n < 8; n++) begin
         done = (n == spur);
         check("start", 64'(o_start), 64'(n == 0));
         check("o_a", 64'(o_a), 64'((a >> (4 * n)) & 32'hF));
         check("o_prime", 64'(o_prime), 64'((p >> (4 * n)) & 32'hF));
         check("o_px", 64'(o_px), 64'((x >> (4 * n)) & 32'hF));
         check("o_py", 64'(o_py), 64'((y >> (4 * n)) & 32'hF));
         check("o_k", 64'(o_k), 64'((k >> (4 * n)) & 32'hF));
         check("send_busy", 64'(hif.req_ready), 64'd0);
         step();
      end
      done = 1'b0;
      check("wait_start0", 64'(o_start), 64'd0);
      check("wait_oa0", 64'(o_a), 64'd0);
      check("wait_busy", 64'(hif.req_ready), 64'd0);
   endtask

   task automatic pulse_done();
      done = 1'b1;
      step();
      done = 1'b0;
   endtask

   task automatic drive_nibs(input logic [31:0] x, input logic [31:0] y,
                             input int cnt);
      for (int n = 0; n < cnt; n++) begin
         kPx = x[4*n +: 4];
         kPy = y[4*n +: 4];
         step();
      end
      kPx = 4'h0;
      kPy = 4'h0;
   endtask

   task automatic release_rsp();
      hif.rsp_ready = 1'b1;
      step();
      hif.rsp_ready = 1'b0;
      check("rel_valid", 64'(hif.rsp_valid), 64'd0);
      check("rel_ready", 64'(hif.req_ready), 64'd1);
   endtask

   initial begin
      logic seen;
      hif.req_valid = 1'b0;
      hif.req_a     = '0;
      hif.req_prime = '0;
      hif.req_px    = '0;
      hif.req_py    = '0;
      hif.req_k     = '0;
      hif.rsp_ready = 1'b0;

      // reset state
      step();
      step();
      check("rst_ready", 64'(hif.req_ready), 64'd1);
      check("rst_start", 64'(o_start), 64'd0);
      check("rst_oa", 64'(o_a), 64'd0);
      check("rst_valid", 64'(hif.rsp_valid), 64'd0);
      check("rst_err", 64'(hif.rsp_err), 64'd0);
      check("rst_x", 64'(hif.rsp_x), 64'd0);
      i_rst = 1'b0;
      step();

      // nominal transaction with back-pressure
      send_req(32'h7654_3210, -1);
      step();
      step();
      pulse_done();
      drive_nibs(32'hFEDC_BA98, 32'h7654_3210, 8);
      check("ok_valid", 64'(hif.rsp_valid), 64'd1);
      check("ok_x", 64'(hif.rsp_x), 64'hFEDC_BA98);
      check("ok_y", 64'(hif.rsp_y), 64'h7654_3210);
      check("ok_err", 64'(hif.rsp_err), 64'd0);
      check("hold_busy", 64'(hif.req_ready), 64'd0);
      for (int i = 0; i < 20; i++) begin
         step();
         check("bp_valid", 64'(hif.rsp_valid), 64'd1);
         check("bp_x", 64'(hif.rsp_x), 64'hFEDC_BA98);
         check("bp_y", 64'(hif.rsp_y), 64'h7654_3210);
      end
      release_rsp();

      // timeout: exactly 16 WAIT cycles without done
      send_req(32'hA5A5_5A5A, -1);
      for (int i = 0; i < 15; i++) step();
      check("tmo_early", 64'(hif.rsp_valid), 64'd0);
      step();
      check("tmo_valid", 64'(hif.rsp_valid), 64'd1);
      check("tmo_err", 64'(hif.rsp_err), 64'd1);
      check("tmo_x", 64'(hif.rsp_x), 64'd0);
      check("tmo_y", 64'(hif.rsp_y), 64'd0);
      pulse_done();
      check("tmo_hold", 64'(hif.rsp_err), 64'd1);
      release_rsp();
      check("tmo_err_clr", 64'(hif.rsp_err), 64'd0);

      // reset in the middle of RECV nibble 3
      send_req(32'h1357_9BDF, -1);
      pulse_done();
      drive_nibs(32'h1111_1111, 32'h2222_2222, 3);
      kPx = 4'h1;
      kPy = 4'h2;
      #2;
      i_rst = 1'b1;
      #1;
      check("mid_rst_ready", 64'(hif.req_ready), 64'd1);
      check("mid_rst_valid", 64'(hif.rsp_valid), 64'd0);
      check("mid_rst_x", 64'(hif.rsp_x), 64'd0);
      step();
      i_rst = 1'b0;
      kPx = 4'h0;
      kPy = 4'h0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         seen = seen | hif.rsp_valid;
      end
      check("no_partial", 64'(seen), 64'd0);
      send_req(32'h0BAD_CAFE, -1);
      step();
      pulse_done();
      drive_nibs(32'h1234_5678, 32'h9ABC_DEF0, 8);
      check("post_rst_valid", 64'(hif.rsp_valid), 64'd1);
      check("post_rst_x", 64'(hif.rsp_x), 64'h1234_5678);
      check("post_rst_y", 64'(hif.rsp_y), 64'h9ABC_DEF0);
      release_rsp();

      // spurious done in SEND cycle 4; stray req_valid during WAIT
      send_req(32'hDEAD_BEEF, 4);
      hif.req_valid = 1'b1;
      hif.req_a     = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) step();
      hif.req_valid = 1'b0;
      check("spur_busy", 64'(hif.req_ready), 64'd0);
      check("spur_wait", 64'(hif.rsp_valid), 64'd0);
      pulse_done();
      drive_nibs(32'hCAFE_F00D, 32'h0000_0001, 7);
      kPx = 4'hC;
      kPy = 4'h0;
      hif.rsp_ready = 1'b1;
      step();
      kPx = 4'h0;
      check("spur_valid", 64'(hif.rsp_valid), 64'd1);
      check("spur_x", 64'(hif.rsp_x), 64'hCAFE_F00D);
      check("spur_y", 64'(hif.rsp_y), 64'h0000_0001);
      step();
      hif.rsp_ready = 1'b0;
      check("nobypass_valid", 64'(hif.rsp_valid), 64'd0);
      check("nobypass_ready", 64'(hif.req_ready), 64'd1);
      step();
      check("idle_start", 64'(o_start), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
